// File: rtl/ppu_pkg.sv
// Shared PPU timing constants and the raster-position type used by the
// timing generator and the fetch/sprite stages.
package ppu_pkg;

    localparam int unsigned DOTS_PER_LINE   = 341;
    localparam int unsigned LINES_PER_FRAME = 262;
    localparam int unsigned VISIBLE_LINES   = 240;
    localparam int unsigned VISIBLE_DOTS    = 256;
    localparam int unsigned VBLANK_LINE     = 241;
    localparam int unsigned PRERENDER_LINE  = 261;
    localparam int unsigned SKIP_DOT        = 339;

    typedef struct packed {
        logic [8:0] scanline;
        logic [8:0] dot;
    } ppu_pos_t;

endpackage

// File: rtl/ppu_timing_gen_counter.sv
// Generic enabled up/down counter with synchronous clear, used for the
// dot and scanline positions.
module ppu_timing_gen_counter #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: hold unless enabled; clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (clr_i) begin
                cnt_d = '0;
            end else if (up_i) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ppu_timing_gen.sv
// PPU scanline/dot timing generator: raster position, visible window,
// rendering qualifier, vblank/NMI and the odd-frame dot skip.
module ppu_timing_gen #(
    parameter int unsigned DOTS_PER_LINE   = ppu_pkg::DOTS_PER_LINE,
    parameter int unsigned LINES_PER_FRAME = ppu_pkg::LINES_PER_FRAME,
    parameter int unsigned VBLANK_LINE     = ppu_pkg::VBLANK_LINE,
    parameter int unsigned PRERENDER_LINE  = ppu_pkg::PRERENDER_LINE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       rendering_en,
    input  logic       nmi_en,
    input  logic       status_rd,
    output logic [8:0] dot,
    output logic [8:0] scanline,
    output logic [7:0] x_pix,
    output logic [7:0] y_pix,
    output logic       visible,
    output logic       rendering_line,
    output logic       frame_odd,
    output logic       vblank,
    output logic       nmi_n,
    output logic       new_frame
);

    import ppu_pkg::*;

    localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] SKIP_AT   = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] LAST_LINE = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] VBL_LINE  = 9'(VBLANK_LINE);
    localparam logic [8:0] PRE_LINE  = 9'(PRERENDER_LINE);
    localparam logic [8:0] VIS_LINES = 9'(VISIBLE_LINES);
    localparam logic [8:0] VIS_DOTS  = 9'(VISIBLE_DOTS);

    logic [8:0] dot_q;
    logic [8:0] scanline_q;
    ppu_pos_t   pos;

    logic frame_odd_q, frame_odd_d;
    logic vblank_q,    vblank_d;
    logic new_frame_q, new_frame_d;

    logic at_last_dot;
    logic odd_skip;
    logic line_wrap;
    logic frame_wrap;
    logic vblank_set;
    logic vblank_clr;

    assign pos = {scanline_q, dot_q};

    // Wrap decode: end of line, end of frame and the odd-frame shortcut
    // from the pre-render line's second-to-last dot straight to (0,0).
    always_comb begin
        at_last_dot = (pos.dot == LAST_DOT);
        odd_skip    = (pos.scanline == PRE_LINE) && (pos.dot == SKIP_AT)
                      && frame_odd_q && rendering_en;
        line_wrap   = at_last_dot || odd_skip;
        frame_wrap  = ((pos.scanline == LAST_LINE) && at_last_dot) || odd_skip;
        vblank_set  = (pos.scanline == VBL_LINE) && (pos.dot == 9'd0);
        vblank_clr  = (pos.scanline == PRE_LINE) && (pos.dot == 9'd0);
    end

    ppu_timing_gen_counter #(
        .WIDTH (9)
    ) u_dot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (clk_en),
        .clr_i (line_wrap),
        .up_i  (1'b1),
        .cnt_o (dot_q)
    );

    ppu_timing_gen_counter #(
        .WIDTH (9)
    ) u_line_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (clk_en && line_wrap),
        .clr_i (frame_wrap),
        .up_i  (1'b1),
        .cnt_o (scanline_q)
    );

    // Frame parity, new-frame pulse and vblank next state. A PPUSTATUS
    // read wins over a same-edge set, so that frame's vblank is lost.
    always_comb begin
        frame_odd_d = frame_odd_q ^ (clk_en && frame_wrap);
        new_frame_d = clk_en && frame_wrap;
        vblank_d    = vblank_q;
        if (clk_en && vblank_set) begin
            vblank_d = 1'b1;
        end else if (clk_en && vblank_clr) begin
            vblank_d = 1'b0;
        end
        if (status_rd) begin
            vblank_d = 1'b0;
        end
    end

    // Frame-level state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_odd_q <= 1'b0;
            vblank_q    <= 1'b0;
            new_frame_q <= 1'b0;
        end else begin
            frame_odd_q <= frame_odd_d;
            vblank_q    <= vblank_d;
            new_frame_q <= new_frame_d;
        end
    end

    assign dot            = pos.dot;
    assign scanline       = pos.scanline;
    assign x_pix          = 8'(pos.dot - 9'd1);
    assign y_pix          = pos.scanline[7:0];
    assign visible        = (pos.scanline < VIS_LINES) && (pos.dot >= 9'd1)
                            && (pos.dot <= VIS_DOTS);
    assign rendering_line = rendering_en
                            && ((pos.scanline < VIS_LINES) || (pos.scanline == PRE_LINE));
    assign frame_odd      = frame_odd_q;
    assign vblank         = vblank_q;
    assign nmi_n          = ~(vblank_q & nmi_en);
    assign new_frame      = new_frame_q;

endmodule

// File: tb/tb_ppu_timing_gen.sv
// Testbench for ppu_timing_gen: a full-size instance for raster/window
// checks and a reduced-geometry instance for frame-level behaviour.
module tb_ppu_timing_gen;

    logic clk;
    logic rst_n;
    logic clk_en_b, clk_en_s;
    logic rendering_en, nmi_en, status_rd;

    logic [8:0] b_dot, b_line, s_dot, s_line;
    logic [7:0] b_x, b_y, s_x, s_y;
    logic b_vis, b_rl, b_odd, b_vb, b_nmi, b_nf;
    logic s_vis, s_rl, s_odd, s_vb, s_nmi, s_nf;

    int n_chk  = 0;
    int n_fail = 0;

    ppu_timing_gen u_big (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_en         (clk_en_b),
        .rendering_en   (rendering_en),
        .nmi_en         (nmi_en),
        .status_rd      (status_rd),
        .dot            (b_dot),
        .scanline       (b_line),
        .x_pix          (b_x),
        .y_pix          (b_y),
        .visible        (b_vis),
        .rendering_line (b_rl),
        .frame_odd      (b_odd),
        .vblank         (b_vb),
        .nmi_n          (b_nmi),
        .new_frame      (b_nf)
    );

    // 20 dots x 12 lines, vblank on line 8, pre-render line 11, skip at dot 18.
    ppu_timing_gen #(
        .DOTS_PER_LINE   (20),
        .LINES_PER_FRAME (12),
        .VBLANK_LINE     (8),
        .PRERENDER_LINE  (11)
    ) u_sml (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_en         (clk_en_s),
        .rendering_en   (rendering_en),
        .nmi_en         (nmi_en),
        .status_rd      (status_rd),
        .dot            (s_dot),
        .scanline       (s_line),
        .x_pix          (s_x),
        .y_pix          (s_y),
        .visible        (s_vis),
        .rendering_line (s_rl),
        .frame_odd      (s_odd),
        .vblank         (s_vb),
        .nmi_n          (s_nmi),
        .new_frame      (s_nf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         ticks;
        logic       ren;
        logic [8:0] edot;
        logic [8:0] eline;
        logic       evis;
        logic [7:0] ex;
        logic [7:0] ey;
        logic       erl;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_b(input int n);
        for (int i = 0; i < n; i++) begin
            clk_en_b = 1'b1;
            @(posedge clk);
            #1;
        end
        clk_en_b = 1'b0;
    endtask

    task automatic run_s(input int n);
        for (int i = 0; i < n; i++) begin
            clk_en_s = 1'b1;
            @(posedge clk);
            #1;
        end
        clk_en_s = 1'b0;
    endtask

    // Tick the small instance from (0,0) until it returns to (0,0).
    task automatic measure_s(output int len, output int nf);
        len = 0;
        nf  = 0;
        do begin
            clk_en_s = 1'b1;
            @(posedge clk);
            #1;
            len++;
            if (s_nf) nf++;
        end while (!(s_dot == 9'd0 && s_line == 9'd0) && len < 1000);
        clk_en_s = 1'b0;
    endtask

    initial begin
        int len, nf;

        tbl[0] = '{ticks: 1,     ren: 1'b1, edot: 9'd1,   eline: 9'd0,   evis: 1'b1, ex: 8'd0,   ey: 8'd0,   erl: 1'b1};
        tbl[1] = '{ticks: 255,   ren: 1'b1, edot: 9'd256, eline: 9'd0,   evis: 1'b1, ex: 8'd255, ey: 8'd0,   erl: 1'b1};
        tbl[2] = '{ticks: 1,     ren: 1'b0, edot: 9'd257, eline: 9'd0,   evis: 1'b0, ex: 8'd0,   ey: 8'd0,   erl: 1'b0};
        tbl[3] = '{ticks: 83,    ren: 1'b1, edot: 9'd340, eline: 9'd0,   evis: 1'b0, ex: 8'd0,   ey: 8'd0,   erl: 1'b1};
        tbl[4] = '{ticks: 1,     ren: 1'b1, edot: 9'd0,   eline: 9'd1,   evis: 1'b0, ex: 8'd0,   ey: 8'd0,   erl: 1'b1};
        tbl[5] = '{ticks: 33887, ren: 1'b0, edot: 9'd128, eline: 9'd100, evis: 1'b1, ex: 8'd127, ey: 8'd100, erl: 1'b0};

        rst_n        = 1'b0;
        clk_en_b     = 1'b0;
        clk_en_s     = 1'b0;
        rendering_en = 1'b1;
        nmi_en       = 1'b1;
        status_rd    = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("rst_dot",  b_dot,  0);
        chk("rst_line", b_line, 0);
        chk("rst_odd",  b_odd,  0);
        chk("rst_vb",   b_vb,   0);
        chk("rst_nmi",  b_nmi,  1);
        chk("rst_nf",   b_nf,   0);
        chk("rst_vis",  b_vis,  0);
        chk("rst_rl",   b_rl,   1);
        rst_n = 1'b1;

        // ---- small instance: frame 0, vblank/NMI behaviour ----
        rendering_en = 1'b0;
        run_s(160);
        chk("pre_vbl_line", s_line, 8);
        chk("pre_vbl_vb",   s_vb,   0);
        run_s(1);
        chk("vbl_dot",  s_dot, 1);
        chk("vbl_set",  s_vb,  1);
        chk("vbl_nmi",  s_nmi, 0);
        nmi_en = 1'b0;
        #1;
        chk("nmi_off", s_nmi, 1);
        nmi_en = 1'b1;
        #1;
        chk("nmi_reassert", s_nmi, 0);
        run_s(24);
        chk("rd_pos_dot", s_dot, 5);
        status_rd = 1'b1;
        @(posedge clk);
        #1;
        status_rd = 1'b0;
        chk("rd_clear_vb",  s_vb,  0);
        chk("rd_clear_nmi", s_nmi, 1);
        run_s(55);
        chk("f0_end_dot",  s_dot,  0);
        chk("f0_end_line", s_line, 0);
        chk("f0_end_odd",  s_odd,  1);
        chk("f0_nf_hi",    s_nf,   1);
        @(posedge clk);
        #1;
        chk("f0_nf_lo",    s_nf,   0);

        // ---- frame lengths ----
        measure_s(len, nf);
        chk("f1_len_noren", len, 240);
        chk("f1_nf_count",  nf,  1);
        chk("f1_odd",       s_odd, 0);
        rendering_en = 1'b1;
        measure_s(len, nf);
        chk("f2_len_even", len, 240);
        chk("f2_odd",      s_odd, 1);
        measure_s(len, nf);
        chk("f3_len_skip", len, 239);
        chk("f3_odd",      s_odd, 0);
        measure_s(len, nf);
        chk("f4_len_even", len, 240);

        // ---- frame 5 (odd): single tick across the skip ----
        run_s(238);
        chk("skip_at_dot",  s_dot,  18);
        chk("skip_at_line", s_line, 11);
        run_s(1);
        chk("skip_dot",  s_dot,  0);
        chk("skip_line", s_line, 0);
        chk("skip_odd",  s_odd,  0);

        // ---- frame 6: status read coincident with the vblank set ----
        run_s(160);
        clk_en_s  = 1'b1;
        status_rd = 1'b1;
        @(posedge clk);
        #1;
        clk_en_s  = 1'b0;
        status_rd = 1'b0;
        chk("race_dot", s_dot, 1);
        chk("race_vb",  s_vb,  0);
        for (int i = 0; i < 60; i++) begin
            run_s(1);
            chk("race_hold_vb",  s_vb,  0);
            chk("race_hold_nmi", s_nmi, 1);
        end
        chk("race_end_line", s_line, 11);
        run_s(19);

        // ---- frame 7: pre-render clear ----
        rendering_en = 1'b0;
        run_s(161);
        chk("f7_vb_set", s_vb, 1);
        run_s(59);
        chk("f7_pre_line", s_line, 11);
        chk("f7_vb_still", s_vb,   1);
        run_s(1);
        chk("f7_vb_clr", s_vb, 0);
        run_s(19);
        run_s(161);
        chk("f8_vb_set", s_vb, 1);

        // ---- full-size instance: table-driven raster checks ----
        for (int i = 0; i < 6; i++) begin
            rendering_en = tbl[i].ren;
            run_b(tbl[i].ticks);
            chk($sformatf("tbl%0d_dot", i),  b_dot,  tbl[i].edot);
            chk($sformatf("tbl%0d_line", i), b_line, tbl[i].eline);
            chk($sformatf("tbl%0d_vis", i),  b_vis,  tbl[i].evis);
            chk($sformatf("tbl%0d_rl", i),   b_rl,   tbl[i].erl);
            if (tbl[i].evis) begin
                chk($sformatf("tbl%0d_x", i), b_x, tbl[i].ex);
                chk($sformatf("tbl%0d_y", i), b_y, tbl[i].ey);
            end
            if (i == 4) begin
                chk("line1_odd", b_odd, 0);
                chk("line1_vb",  b_vb,  0);
                chk("line1_nmi", b_nmi, 1);
            end
        end

        // ---- freeze with clk_en low ----
        repeat (100) @(posedge clk);
        #1;
        chk("frz_dot",  b_dot,  128);
        chk("frz_line", b_line, 100);
        chk("frz_vis",  b_vis,  1);
        chk("frz_x",    b_x,    127);
        chk("frz_y",    b_y,    100);

        // ---- asynchronous reset mid-line ----
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_b_dot",  b_dot,  0);
        chk("arst_b_line", b_line, 0);
        chk("arst_s_dot",  s_dot,  0);
        chk("arst_s_line", s_line, 0);
        chk("arst_s_vb",   s_vb,   0);
        chk("arst_s_nmi",  s_nmi,  1);
        chk("arst_s_odd",  s_odd,  0);
        #10;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
